// File: rtl/compensated_divider_seq.sv
// compensated_divider_seq: handshaked shift-approximate vs restoring-exact divider with error output.
// Optional running maximum of the error is enabled by defining CDIV_MAXERR_EN.
module compensated_divider_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] app,
  output logic [DW-1:0] acc,
  output logic [VW-1:0] rem,
  output logic [DW-1:0] err,
  output logic          div_by_zero,
  output logic [DW-1:0] err_max
);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
  localparam int CW = $clog2(DW + 1);
  localparam int KW = $clog2(VW + 1);
  logic [1:0]    state;
  logic [DW-1:0] sh, qn, en;
  logic [VW-1:0] dv, pr, prn;
  logic [VW:0]   trial, diff;
  logic [CW-1:0] cnt;
  logic [KW-1:0] k;
  logic          qb, last;
  always_comb begin
    k = '0;
    for (int i = 0; i < VW; i++) if (b[i]) k = KW'(i);
  end
  // sh holds the remaining dividend bits in its top and collects quotient bits at its bottom
  assign trial = {pr, sh[DW-1]};
  assign diff = trial - {1'b0, dv};
  assign qb = ~diff[VW];
  assign prn = qb ? diff[VW-1:0] : trial[VW-1:0];
  assign qn = {sh[DW-2:0], qb};
  assign en = app - qn;
  assign last = state == CALC && cnt == CW'(1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // divide-by-zero reuses CALC for one cycle so it also lands in DONE one edge after accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      dv <= '0;
      pr <= '0;
      cnt <= '0;
      app <= '0;
      acc <= '0;
      rem <= '0;
      err <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sh <= a;
          dv <= b;
          pr <= '0;
          div_by_zero <= b == '0;
          cnt <= b == '0 ? CW'(1) : CW'(DW);
          app <= b == '0 ? '1 : a >> k;
          state <= CALC;
          if (b == '0) begin
            acc <= '1;
            rem <= a[VW-1:0];
            err <= '0;
          end
        end
        CALC: begin
          sh <= qn;
          pr <= prn;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= DONE;
            if (!div_by_zero) begin
              acc <= qn;
              rem <= prn;
              err <= en;
            end
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef CDIV_MAXERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_max <= '0;
    else if (last && !div_by_zero && en > err_max) err_max <= en;
`else
  assign err_max = '0;
`endif
endmodule
